bram_wr_sched: RTL
==================

Name: bram_wr_sched

Overview:
Write-port scheduler for the 24-bit, three-lane simple-dual-port BRAM used as a framebuffer or palette store.
- Shares the BRAM write port (cea/addra/dina) between two requesters (req0, req1) using round-robin arbitration with valid/ready handshakes.
- Contains a fill engine that writes a constant colour over an address range, e.g. a frame clear.
- Sits between the GPU/host write sources and the BRAM instance. The read port is untouched.

Parameters:
DP, 512, BRAM depth in words
AW, $clog2(DP)-1, address MSB index
BDW, 23, data MSB index (3 lanes x 8 bit)

Ports:
clk  in  1  system clock (also drives BRAM clka)
rst  in  1  synchronous reset, active-high
r0_valid  in  1  requester 0 write valid
r0_ready  out  1  requester 0 write accepted this cycle
r0_addr  in  AW+1  requester 0 address
r0_data  in  BDW+1  requester 0 data
r1_valid  in  1  requester 1 write valid
r1_ready  out  1  requester 1 write accepted this cycle
r1_addr  in  AW+1  requester 1 address
r1_data  in  BDW+1  requester 1 data
fill_start  in  1  one-cycle pulse: begin fill
fill_base  in  AW+1  first fill address
fill_len  in  AW+1  word count minus 1
fill_color  in  BDW+1  fill value
fill_busy  out  1  fill in progress
fill_done  out  1  one-cycle pulse after the last fill write
cea  out  1  BRAM write enable
addra  out  AW+1  BRAM write address
dina  out  BDW+1  BRAM write data

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Round-robin pointer goes to 0, which gives req0 priority first.
  - An in-progress fill is abandoned. No fill_done is emitted.
- FSM states: IDLE, FILL.
- IDLE:
  - Arbitration is combinational. Outputs are registered, so cea/addra/dina appear 1 cycle after the handshake.
  - Only r0_valid high: r0_ready=1.
  - Only r1_valid high: r1_ready=1.
  - Both high: grant the side the pointer favours. After any grant, the pointer moves to favour the other side.
  - At most one ready is high per cycle. A ready is never high without its valid.
  - A requester must hold addr/data stable while valid && !ready.
- fill_start in IDLE:
  - Latch base, len and color.
  - Go to FILL and set fill_busy=1 next cycle.
  - fill_start has priority over requesters in that same cycle: both readies are 0.
- FILL:
  - Issues one write per cycle: addra = base+i, dina = color, for i = 0..len.
  - Address wraps modulo DP.
  - Both readies are held at 0.
  - After the write with i=len: return to IDLE, pulse fill_done for 1 cycle, drop fill_busy in that same cycle.
  - Total fill duration is len+1 write cycles.
- fill_start while already in FILL is ignored.
- fill_len=0 writes exactly one word.
- cea is 0 on every cycle with no grant and no fill write.
- Back-to-back grants are allowed every cycle. Each requester reaches full throughput when the other is idle.

Optional Feature:
FILL_ON_RST_EN
- Defined: when rst deasserts, the block enters FILL automatically with base=0, len=DP-1, color=0. fill_busy is asserted and fill_done pulses at the end, exactly as for a commanded fill. Any fill_start during this fill is ignored.
- Undefined: the block leaves reset in IDLE, and fills only on fill_start.

Decomposition:
- Shared package bram_ctrl_pkg holds:
  - FSM state encoding (IDLE=1'b0, FILL=1'b1)
  - lane width constant LANE_W=8
  - lane count N_LANES=3
- Sub-module rr_arb2: a 2-input round-robin arbiter with a registered pointer, inputs req[1:0] and advance, output one-hot grant[1:0]. The fill/FSM logic stays in the top.

Test Plan:
- Arbitration under contention:
  - Stimulus: rst for 2 cycles, then r0 and r1 both valid (r0 addr 0x010 data 0x112233, r1 addr 0x020 data 0x445566) held for 4 cycles.
  - Response: grants alternate r0, r1, r0, r1. cea=1 each cycle starting 1 cycle later, with addra alternating 0x010/0x020.
- Fill over the wrap boundary:
  - Stimulus: fill_start with base=0x1FE, len=3, color=0xFF00FF.
  - Response: writes to 0x1FE, 0x1FF, 0x000, 0x001, each with dina=0xFF00FF. fill_done pulses once, fill_busy is high for exactly 4 cycles, both readies stay 0 throughout.
- Fill preempts a requester:
  - Stimulus: fill_start in the same cycle as r0_valid.
  - Response: r0_ready=0. After fill_done, r0 is granted on the next cycle.
- Reset mid-fill:
  - Stimulus: fill of len=100, rst asserted at write 10.
  - Response: next cycle has cea=0, fill_busy=0 and no fill_done. A subsequent r1 write is accepted.
- Single-word fill and ignored restart:
  - Stimulus: fill len=0, then fill_start pulsed during a len=5 fill.
  - Response: the len=0 fill writes exactly 1 word. The second pulse is ignored, giving exactly 6 writes.
- FILL_ON_RST_EN build:
  - Stimulus: release rst.
  - Response: 512 writes of 0 to addresses 0..511, then fill_done.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM write-port controller: FSM encoding and lane geometry.
package bram_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int LANE_W  = 8;
  localparam int N_LANES = 3;

endpackage

// File: rtl/bram_wr_sched_rr_arb2.sv
// Two-input round-robin arbiter; the pointer flips to favour the other side after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/bram_wr_sched.sv
// BRAM write-port scheduler: round-robin sharing between two requesters plus a constant-colour fill engine.
// Optional FILL_ON_RST_EN: clear the whole BRAM to 0 automatically when reset releases.
module bram_wr_sched
  import bram_ctrl_pkg::*;
#(
  parameter int DP  = 512,
  parameter int AW  = $clog2(DP) - 1,
  parameter int BDW = N_LANES * LANE_W - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [AW:0]   r0_addr,
  input  logic [BDW:0]  r0_data,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [AW:0]   r1_addr,
  input  logic [BDW:0]  r1_data,
  input  logic          fill_start,
  input  logic [AW:0]   fill_base,
  input  logic [AW:0]   fill_len,
  input  logic [BDW:0]  fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          cea,
  output logic [AW:0]   addra,
  output logic [BDW:0]  dina
);

  localparam logic [AW:0]   ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW+1:0] DP_EXT = (AW+2)'(DP);

  state_t       state;
  logic [AW:0]  base_q;
  logic [AW:0]  len_q;
  logic [AW:0]  idx_q;
  logic [BDW:0] color_q;

  logic         start;
  logic [AW:0]  s_base;
  logic [AW:0]  s_len;
  logic [BDW:0] s_color;
  logic [1:0]   req;
  logic [1:0]   grant;
  logic [AW:0]  idx_nxt;

  // Address wrap modulo DP; also correct when DP is not a power of two.
  function automatic logic [AW:0] wrap_add(input logic [AW:0] a, input logic [AW:0] b);
    logic [AW+1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DP_EXT) s = s - DP_EXT;
    return s[AW:0];
  endfunction

`ifdef FILL_ON_RST_EN
  logic boot_q;
  assign start = (state == IDLE) && (fill_start || boot_q);
`else
  assign start = (state == IDLE) && fill_start;
`endif

  always_comb begin
    s_base  = fill_base;
    s_len   = fill_len;
    s_color = fill_color;
`ifdef FILL_ON_RST_EN
    if (boot_q) begin
      s_base  = '0;
      s_len   = (AW+1)'(DP - 1);
      s_color = '0;
    end
`endif
  end

  // A fill start (or any cycle outside IDLE, or reset) masks both requesters.
  assign req      = (!rst && state == IDLE && !start) ? {r1_valid, r0_valid} : 2'b00;
  assign r0_ready = grant[0];
  assign r1_ready = grant[1];
  assign idx_nxt  = idx_q + ONE;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (|grant),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      color_q   <= '0;
`ifdef FILL_ON_RST_EN
      boot_q    <= 1'b1;
`endif
    end else begin
      cea       <= 1'b0;
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Word 0 is issued on the entry edge so writes line up with fill_busy.
            state     <= FILL;
            fill_busy <= 1'b1;
            base_q    <= s_base;
            len_q     <= s_len;
            color_q   <= s_color;
            idx_q     <= '0;
            cea       <= 1'b1;
            addra     <= s_base;
            dina      <= s_color;
`ifdef FILL_ON_RST_EN
            boot_q    <= 1'b0;
`endif
          end else if (grant[0]) begin
            cea   <= 1'b1;
            addra <= r0_addr;
            dina  <= r0_data;
          end else if (grant[1]) begin
            cea   <= 1'b1;
            addra <= r1_addr;
            dina  <= r1_data;
          end
        end
        FILL: begin
          if (idx_q == len_q) begin
            state     <= IDLE;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
          end else begin
            idx_q <= idx_nxt;
            cea   <= 1'b1;
            addra <= wrap_add(base_q, idx_nxt);
            dina  <= color_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
